// File: rtl/loop_ctrl_if.sv
// rtl/loop_ctrl_if.sv - counter-control and step-handshake bundle for loop_ctrl
// master is the controller side; slave is the counter/consumer side.
interface loop_ctrl_if #(
  parameter int W = 4
);
  logic         ld;
  logic [W-1:0] ld_data;
  logic         inc;
  logic [W-1:0] cnt;
  logic         step_valid;
  logic         step_ready;

  modport master (
    output ld, ld_data, inc, step_valid,
    input  cnt, step_ready
  );

  modport slave (
    input  ld, ld_data, inc, step_valid,
    output cnt, step_ready
  );
endinterface

// File: rtl/loop_ctrl.sv
// rtl/loop_ctrl.sv - loop sequencer driving an external up-counter
// Runs limit handshaked steps, cross-checking the counter against a shadow copy.
module loop_ctrl #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] limit,
  input  logic         abort,
  output logic         busy,
  output logic         done,
  output logic         err,
  loop_ctrl_if.master  bus
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN, FIN} state_t;

  state_t       state_q, state_d;
  logic [W-1:0] limit_q, limit_d;
  logic [W-1:0] sh_q, sh_d;
  logic         err_q, err_d;
  logic         ld_q, ld_d;
  logic         step_valid_q, step_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;
  logic         handshake;
  logic         last_step;

  // Abort wins over a same-cycle handshake, so it also masks the increment.
  assign handshake = step_valid_q & bus.step_ready & ~abort;
  assign last_step = (bus.cnt == (limit_q - W'(1)));

  always_comb begin
    state_d = state_q;
    limit_d = limit_q;
    sh_d    = sh_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          limit_d = limit;
          sh_d    = '0;
          err_d   = 1'b0;
          state_d = (limit == '0) ? FIN : LOAD;
        end
      end
      LOAD: state_d = RUN;
      RUN: begin
        if (bus.cnt != sh_q) err_d = 1'b1;
        if (abort) begin
          state_d = IDLE;
        end else if (handshake) begin
          sh_d = sh_q + W'(1);
          if (last_step) state_d = FIN;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Moore outputs are registered from the next state so they track state_q exactly.
    ld_d         = (state_d == LOAD);
    step_valid_d = (state_d == RUN);
    busy_d       = (state_d != IDLE);
    done_d       = (state_d == FIN);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      limit_q      <= '0;
      sh_q         <= '0;
      err_q        <= 1'b0;
      ld_q         <= 1'b0;
      step_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      limit_q      <= limit_d;
      sh_q         <= sh_d;
      err_q        <= err_d;
      ld_q         <= ld_d;
      step_valid_q <= step_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign bus.ld         = ld_q;
  assign bus.ld_data    = '0;
  assign bus.inc        = handshake;
  assign bus.step_valid = step_valid_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_loop_ctrl.sv
// tb/tb_loop_ctrl.sv - scoreboard bench for loop_ctrl
// Stimulus queues expected ld/inc/done events; a negedge monitor pops and compares.
module tb_loop_ctrl;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [W-1:0] limit = '0;
  logic         step_ready = 1'b0;
  logic         force_en = 1'b0;
  logic         busy, done, err;
  logic [W-1:0] cnt_model;

  loop_ctrl_if #(.W(W)) bus ();

  loop_ctrl #(.W(W)) dut (
    .clk   (clk),
    .reset (rst),
    .start (start),
    .limit (limit),
    .abort (abort),
    .busy  (busy),
    .done  (done),
    .err   (err),
    .bus   (bus.master)
  );

  always #5 clk = ~clk;

  // Downstream counter model; force_en corrupts the value seen by the DUT.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)          cnt_model <= '0;
    else if (bus.ld)  cnt_model <= bus.ld_data;
    else if (bus.inc) cnt_model <= cnt_model + W'(1);
  end
  assign bus.cnt        = force_en ? 4'd7 : cnt_model;
  assign bus.step_ready = step_ready;

  typedef struct {
    logic [1:0] kind;
    logic [3:0] val;
  } evt_t;
  localparam logic [1:0] K_LD = 2'd0, K_INC = 2'd1, K_DONE = 2'd2;

  evt_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic push(input logic [1:0] kind, input logic [3:0] val);
    evt_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  task automatic push_run(input int n_inc, input logic done_err);
    push(K_LD, 4'd0);
    for (int i = 0; i < n_inc; i++) push(K_INC, 4'(i));
    push(K_DONE, {3'b0, done_err});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_loop(input logic [W-1:0] lim);
    start = 1'b1;
    limit = lim;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(busy), 32'(0));
  endtask

  always @(negedge clk) begin
    if (!rst && (bus.ld || bus.inc || done)) begin
      logic [1:0] k;
      logic [3:0] v;
      evt_t       e;
      k = bus.ld ? K_LD : (bus.inc ? K_INC : K_DONE);
      v = bus.ld ? bus.ld_data : (bus.inc ? bus.cnt : {3'b0, err});
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d val %0h expected none at %0t", k, v, $time);
      end else begin
        e = exp_q.pop_front();
        check("evt_kind", 32'(k), 32'(e.kind));
        check("evt_val", 32'(v), 32'(e.val));
      end
    end
  end

  initial begin
    logic [6:0] pat;
    pat = 7'b1011001;

    #2;
    check("reset_outputs", 32'({bus.ld, bus.inc, bus.step_valid, busy, done, err}), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    tick();

    // limit=3, ready held high
    step_ready = 1'b1;
    push_run(3, 1'b0);
    start_loop(4'd3);
    check("t1_ld", 32'(bus.ld), 32'(1));
    tick();
    check("t1_ld_one_cycle", 32'(bus.ld), 32'(0));
    wait_idle("t1_idle");
    check("t1_cnt", 32'(cnt_model), 32'(3));

    // limit=0 goes straight to FIN
    step_ready = 1'b0;
    push(K_DONE, 4'd0);
    start_loop(4'd0);
    check("t2_busy", 32'(busy), 32'(1));
    check("t2_done", 32'(done), 32'(1));
    tick();
    check("t2_busy_low", 32'(busy), 32'(0));

    // limit=4 with ready pattern 1,0,0,1,1,0,1
    push_run(4, 1'b0);
    start_loop(4'd4);
    tick();
    for (int i = 0; i < 7; i++) begin
      step_ready = pat[i];
      #1 check("t3_inc", 32'(bus.inc), 32'(pat[i]));
      tick();
    end
    step_ready = 1'b0;
    wait_idle("t3_idle");
    check("t3_cnt", 32'(cnt_model), 32'(4));
    check("t3_err", 32'(err), 32'(0));

    // abort after the 2nd handshake of limit=5
    step_ready = 1'b1;
    push(K_LD, 4'd0);
    push(K_INC, 4'd0);
    push(K_INC, 4'd1);
    start_loop(4'd5);
    tick();
    tick();
    tick();
    abort = 1'b1;
    #1 check("t4_inc_masked", 32'(bus.inc), 32'(0));
    tick();
    check("t4_idle", 32'(busy), 32'(0));
    abort = 1'b0;
    tick();
    tick();
    check("t4_cnt", 32'(cnt_model), 32'(2));

    // counter mismatch sets sticky err
    step_ready = 1'b0;
    push_run(3, 1'b1);
    start_loop(4'd3);
    tick();
    force_en = 1'b1;
    #1 check("t5_err_before", 32'(err), 32'(0));
    tick();
    force_en = 1'b0;
    check("t5_err_set", 32'(err), 32'(1));
    step_ready = 1'b1;
    wait_idle("t5_idle");
    check("t5_err_sticky", 32'(err), 32'(1));
    step_ready = 1'b0;
    push(K_DONE, 4'd0);
    start_loop(4'd0);
    check("t5_err_cleared", 32'(err), 32'(0));
    tick();

    // max limit, limit input changed mid-loop
    step_ready = 1'b1;
    push_run(15, 1'b0);
    start_loop(4'd15);
    limit = 4'd1;
    wait_idle("t6_idle");
    check("t6_cnt", 32'(cnt_model), 32'(15));

    // asynchronous reset mid-RUN, then a clean limit=1 loop
    push(K_LD, 4'd0);
    push(K_INC, 4'd0);
    push(K_INC, 4'd1);
    push(K_INC, 4'd2);
    start_loop(4'd15);
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    #1 check("t7_reset_outputs", 32'({bus.ld, bus.inc, bus.step_valid, busy, done, err}), 32'(0));
    tick();
    tick();
    rst = 1'b0;
    push_run(1, 1'b0);
    start_loop(4'd1);
    wait_idle("t7_idle");
    check("t7_cnt", 32'(cnt_model), 32'(1));

    tick();
    tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
